// File: rtl/sr_lock_pkg.sv
// ---------------------------------------------------------------------------
// sr_lock_pkg
// Shared constants for the SR lock arbiter: request opcodes and the FSM
// state encodings used by sr_lock_arbiter.
// ---------------------------------------------------------------------------
package sr_lock_pkg;

    // Request opcodes carried on req_op.
    localparam logic OP_ACQUIRE = 1'b0;
    localparam logic OP_RELEASE = 1'b1;

    // Transaction FSM: capture -> evaluate -> respond.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage : sr_lock_pkg

// File: rtl/sr_lock_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans requests starting at ptr and
// wrapping at N-1 -> 0; the first asserted request wins.
// Ports:
//   req    in  N   request vector
//   ptr    in  W   index with highest priority this round
//   grant  out N   one-hot winner (all zero when no request)
//   index  out W   binary index of the winner (0 when no request)
// The pointer register itself lives in the parent.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] index
);

    logic         found;
    logic [W-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/sr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// sr_lock_arbiter
// Hardware semaphore bank: NUM_LOCKS SR-style flags shared by NUM_REQ
// requesters. One request is served per 3-cycle transaction
// (IDLE capture -> EXEC evaluate -> RESP grant) under round-robin
// arbitration. Each held flag records its owner; only the owner may release.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   per-requester request, held until its gnt pulse
//   req_op     in   per-requester op (0 = acquire, 1 = release)
//   req_id     in   per-requester lock index, slice r = [r*LOCK_W +: LOCK_W]
//   clr_all    in   synchronous clear of all flags and owners
//   gnt        out  one-hot single-cycle completion pulse
//   gnt_ok     out  qualifies gnt: 1 = op succeeded, 0 = refused
//   lock_q     out  current flag state (1 = held)
//   busy       out  high while the FSM is in RESP
// ---------------------------------------------------------------------------
module sr_lock_arbiter
    import sr_lock_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_LOCKS = 4,
    localparam int LOCK_W   = $clog2(NUM_LOCKS),
    localparam int REQ_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*LOCK_W-1:0] req_id,
    input  logic                      clr_all,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      gnt_ok,
    output logic [NUM_LOCKS-1:0]      lock_q,
    output logic                      busy
);

    // Lock count at the id width plus one bit, for the range check.
    localparam logic [LOCK_W:0] NUM_LOCKS_EXT = (LOCK_W + 1)'(NUM_LOCKS);

    logic [1:0]           state_q,   state_d;
    logic [REQ_W-1:0]     ptr_q,     ptr_d;
    logic [REQ_W-1:0]     win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0]   win_oh_q,  win_oh_d;
    logic                 op_q,      op_d;
    logic [LOCK_W-1:0]    id_q,      id_d;
    logic [NUM_LOCKS-1:0] lock_d;
    logic [REQ_W-1:0]     owner_q [NUM_LOCKS];
    logic [REQ_W-1:0]     owner_d [NUM_LOCKS];
    logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
    logic                 gnt_ok_q,  gnt_ok_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [REQ_W-1:0]     arb_idx;
    logic [LOCK_W-1:0]    req_id_arr [NUM_REQ];
    logic                 id_in_range;
    logic                 exec_ok;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_id_unpack
        assign req_id_arr[r] = req_id[r*LOCK_W +: LOCK_W];
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .index (arb_idx)
    );

    // Only matters when NUM_LOCKS is not a power of two.
    assign id_in_range = {1'b0, id_q} < NUM_LOCKS_EXT;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        op_d      = op_q;
        id_d      = id_q;
        lock_d    = lock_q;
        owner_d   = owner_q;
        gnt_d     = '0;
        gnt_ok_d  = 1'b0;
        exec_ok   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    win_idx_d = arb_idx;
                    win_oh_d  = arb_grant;
                    op_d      = req_op[arb_idx];
                    id_d      = req_id_arr[arb_idx];
                    ptr_d     = (arb_idx == REQ_W'(NUM_REQ - 1)) ? '0
                                                                : arb_idx + REQ_W'(1);
                    state_d   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // A single op touches a single flag, so set and clear can
                // never meet on the same flag in one cycle.
                if (id_in_range) begin
                    if (op_q == OP_ACQUIRE) begin
                        // Not re-entrant: a held flag refuses even its owner.
                        if (!lock_q[id_q]) begin
                            lock_d[id_q]  = 1'b1;
                            owner_d[id_q] = win_idx_q;
                            exec_ok       = 1'b1;
                        end
                    end else if (op_q == OP_RELEASE) begin
                        if (lock_q[id_q] && (owner_q[id_q] == win_idx_q)) begin
                            lock_d[id_q] = 1'b0;
                            exec_ok      = 1'b1;
                        end
                    end
                end
                gnt_d    = win_oh_q;
                // A concurrent clear wipes the update, so report refusal.
                gnt_ok_d = exec_ok && !clr_all;
                state_d  = ST_RESP;
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // Clear overrides any EXEC update made above.
        if (clr_all) begin
            lock_d = '0;
            for (int l = 0; l < NUM_LOCKS; l++) begin
                owner_d[l] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value of its peers.
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            op_q      <= OP_ACQUIRE;
            id_q      <= '0;
            lock_q    <= '0;
            gnt_q     <= '0;
            gnt_ok_q  <= 1'b0;
            // NOTE: the owner table is a handful of flops, not a RAM, and
            // reset must clear ownership, so it is reset element by element.
            for (int l = 0; l < NUM_LOCKS; l++) begin
                owner_q[l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            op_q      <= op_d;
            id_q      <= id_d;
            lock_q    <= lock_d;
            gnt_q     <= gnt_d;
            gnt_ok_q  <= gnt_ok_d;
            owner_q   <= owner_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_ok = gnt_ok_q;
    assign busy   = (state_q == ST_RESP);

endmodule : sr_lock_arbiter

// File: tb/tb_sr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_lock_arbiter
// Directed testbench for sr_lock_arbiter (4 requesters, 4 locks).
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_sr_lock_arbiter;
    import sr_lock_pkg::*;

    localparam int NR = 4;
    localparam int NL = 4;
    localparam int LW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_op;
    logic [NR*LW-1:0] req_id;
    logic          clr_all;
    logic [NR-1:0] gnt;
    logic          gnt_ok;
    logic [NL-1:0] lock_q;
    logic          busy;

    int checks = 0;
    int errors = 0;

    sr_lock_arbiter #(
        .NUM_REQ   (NR),
        .NUM_LOCKS (NL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_id    (req_id),
        .clr_all   (clr_all),
        .gnt       (gnt),
        .gnt_ok    (gnt_ok),
        .lock_q    (lock_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic op, input logic [LW-1:0] id);
        req_op[r]           = op;
        req_id[r*LW +: LW]  = id;
        req_valid[r]        = 1'b1;
    endtask

    // Waits (bounded) for the next gnt pulse; g stays 0 and lat -1 on timeout.
    task automatic wait_gnt(output logic [NR-1:0] g, output logic ok,
                            output logic b, output int lat);
        g   = '0;
        ok  = 1'b0;
        b   = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (gnt !== '0) begin
                g   = gnt;
                ok  = gnt_ok;
                b   = busy;
                lat = i;
                break;
            end
        end
    endtask

    // Full transaction for one requester: drive, wait for gnt, drop the
    // request, then one more cycle so the FSM is back in IDLE.
    task automatic run_req(input int r, input logic op, input logic [LW-1:0] id,
                           output logic [NR-1:0] g, output logic ok,
                           output logic b, output int lat);
        set_req(r, op, id);
        wait_gnt(g, ok, b, lat);
        req_valid[r] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_id    = '0;
        clr_all   = 1'b0;
        repeat (3) tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b, expected 0000", gnt); end
        checks++; if (gnt_ok !== 1'b0) begin errors++; $display("FAIL reset_gnt_ok: got %b, expected 0", gnt_ok); end
        checks++; if (lock_q !== 4'b0000) begin errors++; $display("FAIL reset_lock_q: got %b, expected 0000", lock_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_acquire();
        logic [NR-1:0] g; logic ok; logic b; int lat;
        set_req(0, OP_ACQUIRE, 2'd2);
        wait_gnt(g, ok, b, lat);
        req_valid[0] = 1'b0;
        checks++; if (lat !== 2) begin errors++; $display("FAIL acq_latency: got %0d, expected 2", lat); end
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL acq_gnt: got %b, expected 0001", g); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL acq_ok: got %b, expected 1", ok); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL acq_busy: got %b, expected 1", b); end
        checks++; if (lock_q !== 4'b0100) begin errors++; $display("FAIL acq_lock_q: got %b, expected 0100", lock_q); end
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL acq_pulse_width: got %b, expected 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL acq_busy_after: got %b, expected 0", busy); end
    endtask

    task automatic test_refuse();
        logic [NR-1:0] g; logic ok; logic b; int lat;
        run_req(1, OP_ACQUIRE, 2'd2, g, ok, b, lat);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL held_acq_gnt: got %b, expected 0010", g); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL held_acq_ok: got %b, expected 0", ok); end
        checks++; if (lock_q !== 4'b0100) begin errors++; $display("FAIL held_acq_lock_q: got %b, expected 0100", lock_q); end
        run_req(1, OP_RELEASE, 2'd2, g, ok, b, lat);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL nonowner_rel_gnt: got %b, expected 0010", g); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL nonowner_rel_ok: got %b, expected 0", ok); end
        checks++; if (lock_q !== 4'b0100) begin errors++; $display("FAIL nonowner_rel_lock_q: got %b, expected 0100", lock_q); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g; logic ok; logic b; int lat;
        int order [4] = '{1, 2, 3, 0};
        logic [NR-1:0] exp_g;
        // Clear, then steer the pointer to 1 via an acquire/release by req 0.
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        checks++; if (lock_q !== 4'b0000) begin errors++; $display("FAIL clr_idle_lock_q: got %b, expected 0000", lock_q); end
        run_req(0, OP_ACQUIRE, 2'd0, g, ok, b, lat);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_prep_acq_ok: got %b, expected 1", ok); end
        run_req(0, OP_RELEASE, 2'd0, g, ok, b, lat);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL owner_rel_ok: got %b, expected 1", ok); end
        checks++; if (lock_q !== 4'b0000) begin errors++; $display("FAIL owner_rel_lock_q: got %b, expected 0000", lock_q); end
        for (int r = 0; r < NR; r++) set_req(r, OP_ACQUIRE, LW'(r));
        for (int k = 0; k < 4; k++) begin
            exp_g = '0;
            exp_g[order[k]] = 1'b1;
            wait_gnt(g, ok, b, lat);
            checks++; if (g !== exp_g) begin errors++; $display("FAIL rr_gnt_%0d: got %b, expected %b", k, g, exp_g); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_ok_%0d: got %b, expected 1", k, ok); end
            req_valid[order[k]] = 1'b0;
            tick();
        end
        checks++; if (lock_q !== 4'b1111) begin errors++; $display("FAIL rr_lock_q: got %b, expected 1111", lock_q); end
    endtask

    task automatic test_clr_during_exec();
        logic [NR-1:0] g; logic ok; logic b; int lat;
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        run_req(2, OP_ACQUIRE, 2'd3, g, ok, b, lat);
        checks++; if (g !== 4'b0100 || ok !== 1'b1) begin errors++; $display("FAIL clr_prep: got gnt %b ok %b, expected 0100 1", g, ok); end
        checks++; if (lock_q !== 4'b1000) begin errors++; $display("FAIL clr_prep_lock_q: got %b, expected 1000", lock_q); end
        set_req(2, OP_RELEASE, 2'd3);
        tick();                 // captured, FSM now in EXEC
        clr_all = 1'b1;
        tick();                 // EXEC evaluated with clr_all high
        clr_all      = 1'b0;
        req_valid[2] = 1'b0;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL clr_exec_gnt: got %b, expected 0100", gnt); end
        checks++; if (gnt_ok !== 1'b0) begin errors++; $display("FAIL clr_exec_ok: got %b, expected 0", gnt_ok); end
        checks++; if (lock_q !== 4'b0000) begin errors++; $display("FAIL clr_exec_lock_q: got %b, expected 0000", lock_q); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        logic [NR-1:0] g; logic ok; logic b; int lat;
        logic pulse_seen;
        run_req(2, OP_ACQUIRE, 2'd1, g, ok, b, lat);
        checks++; if (lock_q !== 4'b0010) begin errors++; $display("FAIL rst_prep_lock_q: got %b, expected 0010", lock_q); end
        set_req(1, OP_ACQUIRE, 2'd0);
        tick();                 // captured, FSM now in EXEC
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exec_busy: got %b, expected 0", busy); end
        rst = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_mid_gnt: got %b, expected 0000", gnt); end
        checks++; if (lock_q !== 4'b0000) begin errors++; $display("FAIL rst_mid_lock_q: got %b, expected 0000", lock_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
        req_valid = '0;
        tick();
        rst = 1'b1;
        pulse_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (gnt !== 4'b0000) pulse_seen = 1'b1;
        end
        checks++; if (pulse_seen !== 1'b0) begin errors++; $display("FAIL rst_aborted_pulse: got %b, expected 0", pulse_seen); end
        // Pointer back at 0: req 1 must beat req 3.
        set_req(1, OP_ACQUIRE, 2'd0);
        set_req(3, OP_ACQUIRE, 2'd2);
        wait_gnt(g, ok, b, lat);
        req_valid[1] = 1'b0;
        checks++; if (g !== 4'b0010 || ok !== 1'b1) begin errors++; $display("FAIL rst_ptr_gnt: got gnt %b ok %b, expected 0010 1", g, ok); end
        tick();
        wait_gnt(g, ok, b, lat);
        req_valid[3] = 1'b0;
        checks++; if (g !== 4'b1000 || ok !== 1'b1) begin errors++; $display("FAIL rst_next_gnt: got gnt %b ok %b, expected 1000 1", g, ok); end
        checks++; if (lock_q !== 4'b0101) begin errors++; $display("FAIL rst_after_lock_q: got %b, expected 0101", lock_q); end
        tick();
    endtask

    task automatic test_release_free();
        logic [NR-1:0] g; logic ok; logic b; int lat;
        run_req(3, OP_RELEASE, 2'd1, g, ok, b, lat);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL free_rel_gnt: got %b, expected 1000", g); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL free_rel_ok: got %b, expected 0", ok); end
        checks++; if (lock_q !== 4'b0101) begin errors++; $display("FAIL free_rel_lock_q: got %b, expected 0101", lock_q); end
    endtask

    task automatic test_drop_early();
        logic [NR-1:0] g; logic ok; logic b; int lat;
        set_req(0, OP_ACQUIRE, 2'd1);
        tick();                 // captured
        req_valid[0] = 1'b0;
        wait_gnt(g, ok, b, lat);
        checks++; if (g !== 4'b0001 || ok !== 1'b1) begin errors++; $display("FAIL drop_gnt: got gnt %b ok %b, expected 0001 1", g, ok); end
        checks++; if (lock_q !== 4'b0111) begin errors++; $display("FAIL drop_lock_q: got %b, expected 0111", lock_q); end
        tick();
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_refuse();
        test_round_robin();
        test_clr_during_exec();
        test_reset_mid_exec();
        test_release_free();
        test_drop_early();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sr_lock_arbiter
